// File: rtl/risc_v_pkg.sv
// Shared definitions for the risc_v core: opcodes, instruction fields and decode class.
// RISC_V_MUL_EN controls whether MUL decodes as an ALU op or as a NOP.
package risc_v_pkg;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    NOP    = 3'd0,
    RR_ALU = 3'd1,
    RM_ALU = 3'd2,
    LOAD   = 3'd3,
    STORE  = 3'd4,
    BRANCH = 3'd5,
    HALT   = 3'd6
  } instr_class_t;

  function automatic instr_class_t classify(input logic [5:0] op);
    instr_class_t cls;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: cls = RR_ALU;
`ifdef RISC_V_MUL_EN
      OP_MUL:                                cls = RR_ALU;
`endif
      OP_ADDI, OP_SUBI, OP_SLTI:             cls = RM_ALU;
      OP_LW:                                 cls = LOAD;
      OP_SW:                                 cls = STORE;
      OP_BNEQZ, OP_BEQZ:                     cls = BRANCH;
      OP_HLT:                                cls = HALT;
      default:                               cls = NOP;
    endcase
    return cls;
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/risc_v_alu.sv
// Combinational ALU shared by register, immediate and address computations.
// The multiplier exists only when RISC_V_MUL_EN is defined.
module risc_v_alu
  import risc_v_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  // Opcode-selected operation; loads and stores reuse the adder for rs+imm
  always_comb begin
    result = 32'd0;
    case (op)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: result = a + b;
      OP_SUB, OP_SUBI:               result = a - b;
      OP_AND:                        result = a & b;
      OP_OR:                         result = a | b;
      OP_SLT, OP_SLTI:               result = {31'd0, ($signed(a) < $signed(b))};
`ifdef RISC_V_MUL_EN
      OP_MUL:                        result = a * b;
`endif
      default:                       result = 32'd0;
    endcase
  end

endmodule

// File: rtl/risc_v.sv
// Five-stage in-order core (IF/ID/EX/MEM/WB) with unified word memory and no interlocks.
// Optional MUL support is selected with RISC_V_MUL_EN.
module risc_v
  import risc_v_pkg::*;
#(
  parameter int MEM_DEPTH = 1024
) (
  input  logic CLK,
  input  logic RST_N,
  output logic HALTED
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [31:0] MEM [0:MEM_DEPTH-1];
  logic [31:0] REG_FILE [0:31];

  function automatic logic [AW-1:0] wrap_addr(input logic [31:0] addr);
    logic [31:0] m;
    m = addr % 32'(MEM_DEPTH);
    return m[AW-1:0];
  endfunction

  logic [31:0]  pc_r;
  logic         halting_r;
  logic         halted_r;

  logic         if_valid_r;
  logic [31:0]  if_ir_r;
  logic [31:0]  if_npc_r;

  logic         ex_valid_r;
  instr_class_t ex_cls_r;
  logic [5:0]   ex_op_r;
  logic [31:0]  ex_a_r;
  logic [31:0]  ex_b_r;
  logic [31:0]  ex_st_r;
  logic [4:0]   ex_dst_r;
  logic [31:0]  ex_npc_r;
  logic [31:0]  ex_imm_r;

  logic         mem_valid_r;
  instr_class_t mem_cls_r;
  logic [31:0]  mem_alu_r;
  logic [31:0]  mem_st_r;
  logic [4:0]   mem_dst_r;

  logic         wb_valid_r;
  instr_class_t wb_cls_r;
  logic [31:0]  wb_val_r;
  logic [4:0]   wb_dst_r;

  logic [5:0]   id_op_s;
  logic [4:0]   id_rs_s;
  logic [4:0]   id_rt_s;
  logic [4:0]   id_rd_s;
  logic [31:0]  id_imm_s;
  instr_class_t id_cls_s;
  logic [31:0]  rs_val_s;
  logic [31:0]  rt_val_s;
  logic [4:0]   id_dst_s;
  logic [31:0]  id_b_s;
  logic [31:0]  alu_res_s;
  logic         br_taken_s;
  logic [31:0]  br_target_s;
  logic         halt_dec_s;
  logic         fetch_en_s;
  logic         wb_we_s;
  logic [31:0]  fetch_word_s;
  logic [31:0]  mem_rdata_s;

  assign id_op_s      = if_ir_r[OP_MSB:OP_LSB];
  assign id_rs_s      = if_ir_r[RS_MSB:RS_LSB];
  assign id_rt_s      = if_ir_r[RT_MSB:RT_LSB];
  assign id_rd_s      = if_ir_r[RD_MSB:RD_LSB];
  assign id_imm_s     = sext16(if_ir_r[IMM_MSB:IMM_LSB]);
  assign id_cls_s     = classify(id_op_s);
  assign wb_we_s      = wb_valid_r && (wb_dst_r != 5'd0);
  assign fetch_word_s = MEM[wrap_addr(pc_r)];
  assign mem_rdata_s  = MEM[wrap_addr(mem_alu_r)];
  assign br_target_s  = ex_npc_r + ex_imm_r;
  assign halt_dec_s   = if_valid_r && (id_cls_s == HALT) && !br_taken_s;
  assign fetch_en_s   = !halting_r && !halt_dec_s;
  assign HALTED       = halted_r;

  // Register reads; R0 is hard zero and a same-cycle WB write is passed through
  always_comb begin
    rs_val_s = 32'd0;
    rt_val_s = 32'd0;
    if (id_rs_s == 5'd0) rs_val_s = 32'd0;
    else if (wb_we_s && (wb_dst_r == id_rs_s)) rs_val_s = wb_val_r;
    else rs_val_s = REG_FILE[id_rs_s];
    if (id_rt_s == 5'd0) rt_val_s = 32'd0;
    else if (wb_we_s && (wb_dst_r == id_rt_s)) rt_val_s = wb_val_r;
    else rt_val_s = REG_FILE[id_rt_s];
  end

  // Destination and second operand by class; non-writers carry dst 0
  always_comb begin
    id_dst_s = 5'd0;
    id_b_s   = id_imm_s;
    case (id_cls_s)
      RR_ALU: begin
        id_dst_s = id_rd_s;
        id_b_s   = rt_val_s;
      end
      RM_ALU, LOAD: begin
        id_dst_s = id_rt_s;
        id_b_s   = id_imm_s;
      end
      default: begin
        id_dst_s = 5'd0;
        id_b_s   = id_imm_s;
      end
    endcase
  end

  risc_v_alu u_alu (
    .op     (ex_op_r),
    .a      (ex_a_r),
    .b      (ex_b_r),
    .result (alu_res_s)
  );

  // Branch resolution in EX
  always_comb begin
    br_taken_s = 1'b0;
    if (ex_valid_r && (ex_cls_r == BRANCH)) begin
      if (ex_op_r == OP_BEQZ) br_taken_s = (ex_a_r == 32'd0);
      else br_taken_s = (ex_a_r != 32'd0);
    end else begin
      br_taken_s = 1'b0;
    end
  end

  // Pipeline and control state; reset bubbles every stage
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_r        <= 32'd0;
      halting_r   <= 1'b0;
      halted_r    <= 1'b0;
      if_valid_r  <= 1'b0;
      if_ir_r     <= 32'd0;
      if_npc_r    <= 32'd0;
      ex_valid_r  <= 1'b0;
      ex_cls_r    <= NOP;
      ex_op_r     <= 6'd0;
      ex_a_r      <= 32'd0;
      ex_b_r      <= 32'd0;
      ex_st_r     <= 32'd0;
      ex_dst_r    <= 5'd0;
      ex_npc_r    <= 32'd0;
      ex_imm_r    <= 32'd0;
      mem_valid_r <= 1'b0;
      mem_cls_r   <= NOP;
      mem_alu_r   <= 32'd0;
      mem_st_r    <= 32'd0;
      mem_dst_r   <= 5'd0;
      wb_valid_r  <= 1'b0;
      wb_cls_r    <= NOP;
      wb_val_r    <= 32'd0;
      wb_dst_r    <= 5'd0;
    end else begin
      if (br_taken_s) begin
        pc_r       <= br_target_s;
        if_valid_r <= 1'b0;
      end else if (fetch_en_s) begin
        pc_r       <= pc_r + 32'd1;
        if_valid_r <= 1'b1;
        if_ir_r    <= fetch_word_s;
        if_npc_r   <= pc_r + 32'd1;
      end else begin
        if_valid_r <= 1'b0;
      end
      halting_r   <= halting_r | halt_dec_s;

      ex_valid_r  <= if_valid_r && !br_taken_s;
      ex_cls_r    <= id_cls_s;
      ex_op_r     <= id_op_s;
      ex_a_r      <= rs_val_s;
      ex_b_r      <= id_b_s;
      ex_st_r     <= rt_val_s;
      ex_dst_r    <= id_dst_s;
      ex_npc_r    <= if_npc_r;
      ex_imm_r    <= id_imm_s;

      mem_valid_r <= ex_valid_r;
      mem_cls_r   <= ex_cls_r;
      mem_alu_r   <= alu_res_s;
      mem_st_r    <= ex_st_r;
      mem_dst_r   <= ex_dst_r;

      wb_valid_r  <= mem_valid_r;
      wb_cls_r    <= mem_cls_r;
      wb_val_r    <= (mem_cls_r == LOAD) ? mem_rdata_s : mem_alu_r;
      wb_dst_r    <= mem_dst_r;

      halted_r    <= halted_r | (wb_valid_r && (wb_cls_r == HALT));
    end
  end

  // Architectural state writes; contents survive reset
  always_ff @(posedge CLK) begin
    if (mem_valid_r && (mem_cls_r == STORE)) MEM[wrap_addr(mem_alu_r)] <= mem_st_r;
    if (wb_we_s) REG_FILE[wb_dst_r] <= wb_val_r;
  end

endmodule

// File: tb/tb_risc_v.sv
// Program-level bench for risc_v: a table of instructions with expected register writes
// feeds an in-order scoreboard that is matched against REG_FILE changes every cycle.
module tb_risc_v;
  import risc_v_pkg::*;

  localparam int DEPTH = 1024;
  localparam logic [31:0] SENT = 32'hA5A5_0000;
  localparam int NPROG = 47;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic halted;

  risc_v #(.MEM_DEPTH(DEPTH)) dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .HALTED (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    bit          wr;
    int          rd;
    logic [31:0] val;
  } vec_t;

  typedef struct {
    int          rd;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  vec_t        prog [0:NPROG-1];
  exp_t        sbq [$];
  logic [31:0] shadow [0:31];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;

  function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
    return {op, rs[4:0], rt[4:0], rd[4:0], 11'd0};
  endfunction

  function automatic logic [31:0] ii(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  task automatic setv(input int k, input logic [31:0] ins, input bit w, input int rd, input logic [31:0] v);
    prog[k].instr = ins;
    prog[k].wr    = w;
    prog[k].rd    = rd;
    prog[k].val   = v;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int rd, input logic [31:0] val, input int at);
    exp_t e;
    e.rd  = rd;
    e.val = val;
    e.cyc = at;
    sbq.push_back(e);
  endtask

  task automatic scan();
    exp_t e;
    for (int r = 0; r < 32; r++) begin
      if (dut.REG_FILE[r] !== shadow[r]) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write R%0d actual=%h at cycle %0d", r, dut.REG_FILE[r], cyc);
        end else begin
          e = sbq.pop_front();
          check("wb_dest", 32'(r), 32'(e.rd));
          check("wb_value", dut.REG_FILE[r], e.val);
          check("wb_cycle", 32'(cyc), 32'(e.cyc));
        end
        shadow[r] = dut.REG_FILE[r];
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (mon_en) scan();
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    int c0;
    int c1;
    int c2;
    int untouched [7];
    untouched = '{15, 16, 17, 23, 25, 26, 27};

    // Program: ALU, immediates, memory, branches, R0 handling, squashed HLT, HLT
    for (int k = 0; k < NPROG; k++) setv(k, 32'd0, 1'b0, 0, 32'd0);
    setv(0,  ii(OP_ADDI, 1, 0, 5),        1'b1, 1,  32'd5);
    setv(1,  ii(OP_ADDI, 2, 0, 10),       1'b1, 2,  32'd10);
    setv(4,  rr(OP_ADD, 3, 1, 2),         1'b1, 3,  32'd15);
    setv(5,  rr(OP_SUB, 4, 2, 1),         1'b1, 4,  32'd5);
    setv(6,  rr(OP_AND, 5, 1, 2),         1'b1, 5,  32'd0);
    setv(7,  rr(OP_OR, 6, 1, 2),          1'b1, 6,  32'd15);
    setv(8,  rr(OP_SLT, 7, 1, 2),         1'b1, 7,  32'd1);
`ifdef RISC_V_MUL_EN
    setv(9,  rr(OP_MUL, 8, 1, 2),         1'b1, 8,  32'd50);
`else
    setv(9,  rr(OP_MUL, 8, 1, 2),         1'b0, 0,  32'd0);
`endif
    setv(10, ii(OP_ADDI, 9, 1, 15),       1'b1, 9,  32'd20);
    setv(11, ii(OP_SUBI, 10, 2, 3),       1'b1, 10, 32'd7);
    setv(12, ii(OP_SLTI, 11, 2, 20),      1'b1, 11, 32'd1);
    setv(13, ii(OP_SUBI, 12, 0, 1),       1'b1, 12, 32'hFFFF_FFFF);
    setv(14, ii(OP_SW, 3, 0, 1224),       1'b0, 0,  32'd0);
    setv(17, ii(OP_LW, 12, 0, 200),       1'b1, 12, 32'd15);
    setv(20, rr(OP_ADD, 13, 12, 0),       1'b1, 13, 32'd15);
    setv(21, ii(OP_BEQZ, 0, 1, 5),        1'b0, 0,  32'd0);
    setv(22, ii(OP_ADDI, 14, 0, 7),       1'b1, 14, 32'd7);
    setv(23, ii(OP_BNEQZ, 0, 2, 3),       1'b0, 0,  32'd0);
    setv(24, ii(OP_ADDI, 15, 0, 1),       1'b0, 0,  32'd0);
    setv(25, ii(OP_ADDI, 16, 0, 2),       1'b0, 0,  32'd0);
    setv(26, ii(OP_ADDI, 17, 0, 3),       1'b0, 0,  32'd0);
    setv(27, ii(OP_ADDI, 18, 0, 9),       1'b1, 18, 32'd9);
    setv(28, ii(OP_SUBI, 20, 0, 3),       1'b1, 20, 32'hFFFF_FFFD);
    setv(31, rr(OP_SLT, 19, 20, 1),       1'b1, 19, 32'd1);
    setv(32, ii(OP_SLTI, 21, 1, -1),      1'b1, 21, 32'd0);
    setv(33, ii(OP_ADDI, 22, 1, -7),      1'b1, 22, 32'hFFFF_FFFE);
    setv(34, {6'b010000, 5'd1, 5'd23, 16'd5}, 1'b0, 0, 32'd0);
    setv(35, ii(OP_ADDI, 0, 0, 99),       1'b0, 0,  32'd0);
    setv(38, ii(OP_ADDI, 24, 0, 4),       1'b1, 24, 32'd4);
    setv(40, ii(OP_BEQZ, 0, 0, 2),        1'b0, 0,  32'd0);
    setv(41, {OP_HLT, 26'd0},             1'b0, 0,  32'd0);
    setv(42, ii(OP_ADDI, 25, 0, 1),       1'b0, 0,  32'd0);
    setv(43, ii(OP_ADDI, 28, 0, 6),       1'b1, 28, 32'd6);
    setv(44, {OP_HLT, 26'd0},             1'b0, 0,  32'd0);
    setv(45, ii(OP_SLTI, 26, 1, 100),     1'b0, 0,  32'd0);
    setv(46, ii(OP_SUBI, 27, 0, 1),       1'b0, 0,  32'd0);

    for (int i = 0; i < DEPTH; i++) dut.MEM[i] = 32'd0;
    for (int r = 0; r < 32; r++) begin
      shadow[r] = SENT | 32'(r);
      dut.REG_FILE[r] = SENT | 32'(r);
    end

    step();
    step();
    check("reset_halted", {31'd0, halted}, 32'd0);

    // Release; first edge afterwards fetches address 0. Taken branch at 23 shifts later fetches by -1.
    c0 = cyc;
    for (int k = 0; k < NPROG; k++) begin
      dut.MEM[k] = prog[k].instr;
      if (prog[k].wr) push_exp(prog[k].rd, prog[k].val, c0 + ((k <= 23) ? k + 1 : k) + 4);
    end
    mon_en = 1'b1;
    rst_n = 1'b1;

    run_to(c0 + 17);
    check("sw_not_yet", dut.MEM[200], 32'd0);
    step();
    check("sw_wrapped_addr", dut.MEM[200], 32'd15);
    run_to(c0 + 47);
    check("halted_before_wb", {31'd0, halted}, 32'd0);
    step();
    check("halted_rise", {31'd0, halted}, 32'd1);
    repeat (100) step();
    check("halted_sticky", {31'd0, halted}, 32'd1);
    check("sb_drained_p1", 32'(sbq.size()), 32'd0);
    for (int i = 0; i < 7; i++)
      check($sformatf("untouched_R%0d", untouched[i]), dut.REG_FILE[untouched[i]], SENT | 32'(untouched[i]));
`ifdef RISC_V_MUL_EN
    check("mul_R8", dut.REG_FILE[8], 32'd50);
`else
    check("mul_off_R8", dut.REG_FILE[8], SENT | 32'd8);
`endif
    check("mem40_final", dut.MEM[200], 32'd15);

    // Reset mid-program: async HALTED clear, in-flight writes dropped, refetch from 0
    rst_n = 1'b0;
    #1;
    check("async_reset_halted", {31'd0, halted}, 32'd0);
    dut.MEM[0] = ii(OP_ADDI, 29, 0, 11);
    dut.MEM[1] = ii(OP_ADDI, 30, 0, 22);
    dut.MEM[2] = ii(OP_ADDI, 31, 0, 33);
    for (int i = 3; i < 11; i++) dut.MEM[i] = 32'd0;
    dut.MEM[11] = {OP_HLT, 26'd0};
    step();
    rst_n = 1'b1;
    c1 = cyc;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("midrun_reset_halted", {31'd0, halted}, 32'd0);
    step();
    rst_n = 1'b1;
    c2 = cyc;
    push_exp(29, 32'd11, c2 + 5);
    push_exp(30, 32'd22, c2 + 6);
    push_exp(31, 32'd33, c2 + 7);
    step();
    check("inflight_dropped_R29", dut.REG_FILE[29], SENT | 32'd29);
    run_to(c2 + 15);
    check("halted_before_wb2", {31'd0, halted}, 32'd0);
    step();
    check("halted_rise2", {31'd0, halted}, 32'd1);
    repeat (5) step();
    check("sb_drained_p2", 32'(sbq.size()), 32'd0);
    check("R31_final", dut.REG_FILE[31], 32'd33);
    check("c1_c2_gap", 32'(c2 - c1), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
